pipe_stage_reg: RTL
===================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of each of the two data payload fields.
REQ-002 SHALL have parameter CTRL_W, default 4, width of the control bundle (WB and M bits).
REQ-003 SHALL have parameter ADDR_W, default 5, width of the destination register address.
REQ-004 SHALL have port clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port valid_i  in  1  upstream entry present.
REQ-007 SHALL have port ready_o  out  1  stage can accept an entry this cycle.
REQ-008 SHALL have port flush_i  in  1  discard all held entries and any entry offered this cycle.
REQ-009 SHALL have ports ctrl_i  in  CTRL_W, RDaddr_i  in  ADDR_W, ALUdata_i  in  DATA_W, data_i  in  DATA_W as the upstream payload.
REQ-010 SHALL have port valid_o  out  1  head entry present.
REQ-011 SHALL have port ready_i  in  1  downstream accepts the head entry.
REQ-012 SHALL have ports ctrl_o  out  CTRL_W, RDaddr_o  out  ADDR_W, ALUdata_o  out  DATA_W, data_o  out  DATA_W as the head payload.
REQ-013 SHALL have port FW_o  out  1  equal to ctrl_o[0], the forwarding-enable bit.
REQ-014 SHALL have port count_o  out  2  number of held entries.

Function
REQ-015 SHALL define in_fire = valid_i & ready_o and out_fire = valid_o & ready_i.
REQ-016 SHALL gate ctrl_o to all-zero whenever valid_o=0, so a bubble never asserts write or memory controls.
REQ-017 SHALL drive RDaddr_o, ALUdata_o and data_o from head registers regardless of valid_o.
REQ-018 SHALL implement states EMPTY (count 0), ONE (count 1) and FULL (count 2, skid build only), with valid_o=1 in ONE and FULL.
REQ-019 SHALL transition EMPTY to ONE on in_fire, loading the head with the input payload.
REQ-020 SHALL, in ONE, on in_fire & out_fire, reload the head with the input payload and remain in ONE (zero-bubble throughput).
REQ-021 SHALL, in ONE, on out_fire without in_fire, go to EMPTY.
REQ-022 SHALL, in ONE, on in_fire without out_fire, store the input in the skid register and go to FULL (skid build).
REQ-023 SHALL, in FULL, hold ready_o=0, and on out_fire move skid to head and go to ONE.
REQ-024 SHALL hold all payload registers unchanged when no transition occurs.
REQ-025 SHALL give flush_i priority over every transition: next state EMPTY, count_o=0, any in_fire that cycle discarded, payload registers unchanged.
REQ-026 SHALL preserve entry order; no entry duplicated or dropped except by flush_i or rst_i.
REQ-027 SHALL have latency one cycle from in_fire in EMPTY to valid_o=1.

Reset
REQ-028 SHALL, with rst_i=1 at a clock edge, enter EMPTY and clear valid_o, count_o, ctrl_o, RDaddr_o, ALUdata_o, data_o and the skid register to zero.
REQ-029 SHALL give rst_i priority over flush_i and all handshakes, including mid-transfer in FULL.
REQ-030 SHALL drive ready_o=1 in the cycle after reset.

Configuration
REQ-031 SHALL, with macro PIPE_STAGE_SKID_EN defined, include the skid register and FULL state, and drive ready_o = (state != FULL) purely from registers.
REQ-032 SHALL, without PIPE_STAGE_SKID_EN, omit skid register and FULL, drive ready_o = ~valid_o | ready_i combinationally, and limit count_o to at most 1.

Verification
REQ-033 SHALL check: reset, then valid_i=1, ALUdata_i=0x0000_1234, RDaddr_i=5, ready_i=1 -> next cycle valid_o=1, ALUdata_o=0x0000_1234, RDaddr_o=5, count_o=1.
REQ-034 SHALL check: 8 back-to-back entries with ready_i held 1 -> 8 consecutive out_fire cycles, in order, no bubble.
REQ-035 SHALL check (skid): entries A, B with ready_i=0 -> count_o=2, ready_o=0, ctrl_o=A's ctrl; ready_i=1 for two cycles -> A then B delivered, count_o returns to 0.
REQ-036 SHALL check: flush_i=1 in FULL while valid_i=1 -> next cycle valid_o=0, count_o=0, ctrl_o=0, FW_o=0, offered entry not later delivered.
REQ-037 SHALL check: rst_i=1 asserted together with flush_i and in_fire in ONE -> all outputs zero next cycle, ready_o=1.
REQ-038 SHALL check (no skid): valid_o=1, ready_i=0 -> ready_o=0; ready_i=1 with valid_i=1 -> ready_o=1 same cycle and head replaced next edge.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready handshake, flush, bubble-gated control.
// Define PIPE_STAGE_SKID_EN to add a skid register (FULL state, registered ready_o).
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              flush_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [ADDR_W-1:0] RDaddr_i,
  input  logic [DATA_W-1:0] ALUdata_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [ADDR_W-1:0] RDaddr_o,
  output logic [DATA_W-1:0] ALUdata_o,
  output logic [DATA_W-1:0] data_o,
  output logic              FW_o,
  output logic [1:0]        count_o
);

  // Encoding doubles as the held-entry count.
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;

  state_e            state_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] data_q;
  logic              in_fire;
  logic              out_fire;

`ifdef PIPE_STAGE_SKID_EN
  logic [CTRL_W-1:0] sk_ctrl_q;
  logic [ADDR_W-1:0] sk_rd_q;
  logic [DATA_W-1:0] sk_alu_q;
  logic [DATA_W-1:0] sk_data_q;

  assign ready_o = (state_q != FULL);
`else
  // Without a skid slot the head can only be replaced while it is leaving.
  assign ready_o = ~valid_o | ready_i;
`endif

  assign valid_o   = (state_q != EMPTY);
  assign in_fire   = valid_i & ready_o;
  assign out_fire  = valid_o & ready_i;
  assign ctrl_o    = valid_o ? ctrl_q : '0;
  assign FW_o      = ctrl_o[0];
  assign RDaddr_o  = rd_q;
  assign ALUdata_o = alu_q;
  assign data_o    = data_q;
  assign count_o   = state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      ctrl_q  <= '0;
      rd_q    <= '0;
      alu_q   <= '0;
      data_q  <= '0;
`ifdef PIPE_STAGE_SKID_EN
      sk_ctrl_q <= '0;
      sk_rd_q   <= '0;
      sk_alu_q  <= '0;
      sk_data_q <= '0;
`endif
    end else if (flush_i) begin
      state_q <= EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) begin
          state_q <= ONE;
          ctrl_q  <= ctrl_i;
          rd_q    <= RDaddr_i;
          alu_q   <= ALUdata_i;
          data_q  <= data_i;
        end
        ONE: if (in_fire && out_fire) begin
          ctrl_q <= ctrl_i;
          rd_q   <= RDaddr_i;
          alu_q  <= ALUdata_i;
          data_q <= data_i;
        end else if (out_fire) begin
          state_q <= EMPTY;
`ifdef PIPE_STAGE_SKID_EN
        end else if (in_fire) begin
          state_q   <= FULL;
          sk_ctrl_q <= ctrl_i;
          sk_rd_q   <= RDaddr_i;
          sk_alu_q  <= ALUdata_i;
          sk_data_q <= data_i;
`endif
        end
`ifdef PIPE_STAGE_SKID_EN
        FULL: if (out_fire) begin
          state_q <= ONE;
          ctrl_q  <= sk_ctrl_q;
          rd_q    <= sk_rd_q;
          alu_q   <= sk_alu_q;
          data_q  <= sk_data_q;
        end
`endif
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule
